// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM state encoding, grant owner, default widths.
// Provides state_t (IDLE/GRANT_I/GRANT_D), owner_t (OWNER_I/OWNER_D) and a round-robin helper.
// Default LINE_WIDTH / ADDR_WIDTH used by the arbiter and its interface.
package cache_arb_types;

  localparam int DEF_LINE_WIDTH = 256;
  localparam int DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Round-robin tie breaker: the requester that did not win last time goes next.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory signals around the cache arbiter.
// master: the environment side (caches requesting, memory responding).
// slave:  the arbiter side (consumes requests, drives memory request and cache responses).
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);

  // I-cache port
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  // D-cache port
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  // Shared physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between an I-cache and a D-cache.
// Latency: one cycle from request seen in IDLE to memory request; response passed through combinationally.
// Backpressure: grant is held (non-preemptive) until pmem_resp or owner drops its request.
// Ports: clk, reset (sync, active-high); bus (cache_arbiter_if.slave) carrying both cache ports and memory port.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  cache_arbiter_if.slave bus
);

  state_t state_q, state_d;
  owner_t last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  i_resp;
  logic                  d_resp;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // State register; reset also re-arms the tie breaker so the first tie goes to I.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold a grant until response or owner withdraws.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          last_grant_d = other_owner(last_grant_q);
          state_d      = (other_owner(last_grant_q) == OWNER_I) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
          last_grant_d = OWNER_I;
          state_d      = GRANT_I;
        end else if (d_req) begin
          last_grant_d = OWNER_D;
          state_d      = GRANT_D;
        end
      end
      GRANT_I: if (!i_req || bus.pmem_resp) state_d = IDLE;
      GRANT_D: if (!d_req || bus.pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State actions. While reset is high the outputs are forced to the IDLE
  // values even if the register still holds a grant state. A response is only
  // forwarded while the owner is still requesting, so a withdrawn request never
  // sees a completion pulse.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    if (!reset) begin
      case (state_q)
        GRANT_I: begin
          mem_read = 1'b1;
          mem_addr = bus.i_pmem_address;
          i_resp   = bus.pmem_resp & i_req;
        end
        GRANT_D: begin
          // Write-back takes priority if the D-cache raises both strobes.
          mem_write = bus.d_pmem_write;
          mem_read  = bus.d_pmem_read & ~bus.d_pmem_write;
          mem_addr  = bus.d_pmem_address;
          mem_wdata = bus.d_pmem_wdata;
          d_resp    = bus.pmem_resp & d_req;
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read    = mem_read;
  assign bus.pmem_write   = mem_write;
  assign bus.pmem_address = mem_addr;
  assign bus.pmem_wdata   = mem_wdata;
  assign bus.i_pmem_resp  = i_resp;
  assign bus.d_pmem_resp  = d_resp;

  // Read data is broadcast to both caches; only resp qualifies it.
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then randomized caches/memory.
// A transaction-level model (current owner plus a log of past grants) predicts every output each cycle.
// Inputs are driven 1ns after posedge; outputs are compared on the negedge.
module tb_cache_arbiter;
  import cache_arb_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cur: 0 = memory port free, 1 = I-cache owns it, 2 = D-cache owns it.
  // grant_log: owners in order of grant since the last reset.
  int cur = 0;
  int grant_log[$];

  logic          e_rd, e_wr, e_ir, e_dr;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wd;
  logic          d_any;

  // Observations used by the random agents on the next drive edge.
  logic i_resp_seen = 1'b0;
  logic d_resp_seen = 1'b0;
  logic mem_req_seen = 1'b0;

  always @(negedge clk) begin
    d_any  = bus.d_pmem_read | bus.d_pmem_write;
    e_rd   = 1'b0;
    e_wr   = 1'b0;
    e_addr = '0;
    e_wd   = '0;
    e_ir   = 1'b0;
    e_dr   = 1'b0;
    if (!reset && cur == 1) begin
      e_rd   = 1'b1;
      e_addr = bus.i_pmem_address;
      e_ir   = bus.pmem_resp & bus.i_pmem_read;
    end else if (!reset && cur == 2) begin
      e_wr   = bus.d_pmem_write;
      e_rd   = bus.d_pmem_read & ~bus.d_pmem_write;
      e_addr = bus.d_pmem_address;
      e_wd   = bus.d_pmem_wdata;
      e_dr   = bus.pmem_resp & d_any;
    end
    check("m_pmem_read",    bus.pmem_read,    e_rd);
    check("m_pmem_write",   bus.pmem_write,   e_wr);
    check("m_pmem_address", bus.pmem_address, e_addr);
    check("m_pmem_wdata",   bus.pmem_wdata,   e_wd);
    check("m_i_resp",       bus.i_pmem_resp,  e_ir);
    check("m_d_resp",       bus.d_pmem_resp,  e_dr);
    check("m_i_rdata",      bus.i_pmem_rdata, bus.pmem_rdata);
    check("m_d_rdata",      bus.d_pmem_rdata, bus.pmem_rdata);

    // Advance the model to what the next cycle should look like.
    if (reset) begin
      cur = 0;
      grant_log.delete();
    end else if (cur == 0) begin
      if (bus.i_pmem_read && d_any)
        cur = (grant_log.size() > 0 && grant_log[$] == 1) ? 2 : 1;
      else if (bus.i_pmem_read)
        cur = 1;
      else if (d_any)
        cur = 2;
      if (cur != 0) grant_log.push_back(cur);
    end else begin
      if (!((cur == 1) ? bus.i_pmem_read : d_any) || bus.pmem_resp) cur = 0;
    end

    i_resp_seen  = bus.i_pmem_resp;
    d_resp_seen  = bus.d_pmem_resp;
    mem_req_seen = bus.pmem_read | bus.pmem_write;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [AW-1:0] a_tmp;
  logic [LW-1:0] w_tmp;
  int lat;

  initial begin
    reset              = 1'b1;
    bus.i_pmem_read    = 1'b0;
    bus.i_pmem_address = '0;
    bus.d_pmem_read    = 1'b0;
    bus.d_pmem_write   = 1'b0;
    bus.d_pmem_address = '0;
    bus.d_pmem_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;

    // Reset and the cycle after it: everything idle.
    cyc(); smp();
    check("rst_rw",   {bus.pmem_read, bus.pmem_write}, 0);
    check("rst_resp", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    cyc(); reset = 1'b0; smp();
    check("post_rst_rw", {bus.pmem_read, bus.pmem_write}, 0);

    // I-only fill, memory answers on the fourth granted cycle.
    cyc(); bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_1000;
    w_tmp = {32{8'hA5}}; bus.pmem_rdata = w_tmp; smp();
    check("A_latency", bus.pmem_read, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc(); smp();
      check("A_read", bus.pmem_read, 1);
      check("A_addr", bus.pmem_address, 32'h0000_1000);
      check("A_noresp", bus.i_pmem_resp, 0);
    end
    cyc(); bus.pmem_resp = 1'b1; smp();
    check("A_read4", bus.pmem_read, 1);
    check("A_resp", bus.i_pmem_resp, 1);
    check("A_rdata", bus.i_pmem_rdata, w_tmp);
    check("A_dresp", bus.d_pmem_resp, 0);
    cyc(); bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; smp();
    check("A_done", bus.pmem_read, 0);

    // Ties after reset: I first, then D (I re-requests in the IDLE gap), then I.
    cyc(); reset = 1'b1; smp();
    cyc(); reset = 1'b0;
    bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_3000;
    bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h0000_4000; smp();
    cyc(); smp();
    check("B_first_addr", bus.pmem_address, 32'h0000_3000);
    cyc(); bus.pmem_resp = 1'b1; smp();
    check("B_iresp", bus.i_pmem_resp, 1);
    check("B_dresp0", bus.d_pmem_resp, 0);
    cyc(); bus.pmem_resp = 1'b0; bus.i_pmem_address = 32'h0000_3100; smp();
    check("B_idle_gap", bus.pmem_read, 0);
    cyc(); smp();
    check("B_second_addr", bus.pmem_address, 32'h0000_4000);
    cyc(); bus.pmem_resp = 1'b1; smp();
    check("B_dresp", bus.d_pmem_resp, 1);
    check("B_iresp0", bus.i_pmem_resp, 0);
    cyc(); bus.pmem_resp = 1'b0; bus.d_pmem_read = 1'b0; smp();
    check("B_idle_gap2", bus.pmem_read, 0);
    cyc(); smp();
    check("B_third_addr", bus.pmem_address, 32'h0000_3100);
    cyc(); bus.pmem_resp = 1'b1; smp();
    cyc(); bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; smp();

    // D write-back with I arriving mid-grant and a 5-cycle memory delay.
    cyc(); bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_2040;
    w_tmp = {8{32'h1234_5678}}; bus.d_pmem_wdata = w_tmp; smp();
    cyc(); bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_5000; smp();
    check("C_write", bus.pmem_write, 1);
    check("C_read", bus.pmem_read, 0);
    check("C_wdata", bus.pmem_wdata, w_tmp);
    check("C_addr1", bus.pmem_address, 32'h0000_2040);
    for (int c = 2; c <= 5; c++) begin
      cyc(); smp();
      check("C_addr", bus.pmem_address, 32'h0000_2040);
      check("C_iresp0", bus.i_pmem_resp, 0);
    end
    cyc(); bus.pmem_resp = 1'b1; smp();
    check("C_dresp", bus.d_pmem_resp, 1);
    check("C_iresp", bus.i_pmem_resp, 0);
    cyc(); bus.pmem_resp = 1'b0; bus.d_pmem_write = 1'b0; smp();
    check("C_idle", {bus.pmem_read, bus.pmem_write}, 0);
    cyc(); smp();
    check("C_igrant", bus.pmem_address, 32'h0000_5000);
    cyc(); bus.pmem_resp = 1'b1; smp();
    cyc(); bus.pmem_resp = 1'b0; bus.i_pmem_read = 1'b0; smp();

    // Read+write together, then reset mid-grant and a stale response.
    cyc(); bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_6000; smp();
    cyc(); smp();
    check("D_write", bus.pmem_write, 1);
    check("D_read", bus.pmem_read, 0);
    cyc(); reset = 1'b1; smp();
    check("D_rst_out", {bus.pmem_read, bus.pmem_write}, 0);
    cyc(); reset = 1'b0; bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0; bus.pmem_resp = 1'b1; smp();
    check("D_stale_resp", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
    check("D_idle", {bus.pmem_read, bus.pmem_write}, 0);
    cyc(); bus.pmem_resp = 1'b0; smp();

    // Owner withdraws before the response: no pulse, back to idle.
    cyc(); bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_7000; smp();
    cyc(); smp();
    cyc(); bus.i_pmem_read = 1'b0; bus.pmem_resp = 1'b1; smp();
    check("E_noresp", bus.i_pmem_resp, 0);
    cyc(); bus.pmem_resp = 1'b0; smp();
    check("E_idle", bus.pmem_read, 0);

    // Randomized traffic; the model checks every cycle.
    lat = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < LW / 32; k++) w_tmp[k*32 +: 32] = $urandom;
      bus.pmem_rdata = w_tmp;

      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (mem_req_seen) begin
        if (lat == 0) begin
          bus.pmem_resp = 1'b1;
          lat = $urandom_range(0, 4);
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        bus.pmem_resp = 1'b1;
      end

      if (i_resp_seen) begin
        bus.i_pmem_read = 1'b0;
      end else if (bus.i_pmem_read) begin
        if ($urandom_range(0, 49) == 0) bus.i_pmem_read = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        a_tmp = $urandom;
        bus.i_pmem_read = 1'b1;
        bus.i_pmem_address = a_tmp & ~32'h1f;
      end

      if (d_resp_seen) begin
        bus.d_pmem_read  = 1'b0;
        bus.d_pmem_write = 1'b0;
      end else if (bus.d_pmem_read || bus.d_pmem_write) begin
        if ($urandom_range(0, 49) == 0) begin
          bus.d_pmem_read  = 1'b0;
          bus.d_pmem_write = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        a_tmp = $urandom;
        bus.d_pmem_address = a_tmp & ~32'h1f;
        for (int k = 0; k < LW / 32; k++) w_tmp[k*32 +: 32] = $urandom;
        bus.d_pmem_wdata = w_tmp;
        case ($urandom_range(0, 3))
          0, 1: begin bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b0; end
          2:    begin bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b1; end
          default: begin bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1; end
        endcase
      end
    end

    smp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
